// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32 control FSM: state encoding,
// opcode constants and ALU select encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_MEM = 4'd7,
        S_MEM_WR = 4'd8,
        S_BRANCH = 4'd9,
        S_TRAP   = 4'd10
    } mc_state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // States that hold a memory access open until mem_ready.
    function automatic logic is_mem_state(input mc_state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// Saturating count of consecutive memory wait cycles. mem_timeout latches
// once the count reaches MAX and stays set until reset; the FSM is not
// stalled or redirected by it.
module mc_wait_counter #(
    parameter int unsigned MAX = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    output logic mem_timeout
);

    localparam int unsigned CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear when no wait is pending, otherwise step and saturate.
    always_comb begin
        cnt_d = '0;
        if (waiting) begin
            if (cnt_q == CW'(MAX)) cnt_d = cnt_q;
            else                   cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            mem_timeout <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (cnt_d == CW'(MAX)) mem_timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the shared-ALU / shared-memory multi-cycle RV32 subset
// datapath (R-type, LW, SW, BEQ). Outputs are decoded from the state register;
// only ir_write, pc_write and instr_done are qualified by mem_ready.
// Build option: ILLEGAL_TRAP_EN sends unknown opcodes to an absorbing TRAP
// state and raises illegal; without it unknown opcodes retire as NOPs.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | post-reset, one cycle, all outputs low
// FETCH  | read instruction at PC, PC += 4 when memory completes
// DECODE | dispatch on opcode, branch target into ALUOut
// EXEC_R | R-type ALU operation rs1 op rs2
// WB_R   | write ALUOut to rd
// ADDR   | effective address rs1 + imm
// MEM_RD | load access at ALUOut
// WB_MEM | write MDR to rd
// MEM_WR | store access at ALUOut
// BRANCH | compare rs1 - rs2, conditional PC load from ALUOut
// TRAP   | unknown opcode, held until reset
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       pc_source,
    output logic       instr_done,
    output logic       mem_timeout,
    output logic       illegal,
    output logic [3:0] state
);

    mc_state_e state_q;
    mc_state_e state_d;
    logic      is_store_q;

    // zero is combined with pc_write_cond in the datapath PC-enable logic.
    logic unused_zero;
    assign unused_zero = zero;

    assign state = state_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Capture load/store at DECODE so IR changes during ADDR cannot misroute.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    is_store_q <= 1'b0;
        else if (state_q == S_DECODE)  is_store_q <= (opcode == OP_STORE);
    end

    // Next-state and output decode.
    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_ADD;
        pc_source     = 1'b0;
        instr_done    = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_LOAD, OP_STORE:  state_d = S_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        state_d    = S_FETCH;
                        instr_done = 1'b1;
`endif
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = S_WB_R;
            end
            S_WB_R: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = is_store_q ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = S_WB_MEM;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
                instr_done    = 1'b1;
                state_d       = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky illegal flag, set on the way into TRAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 illegal_q <= 1'b0;
        else if (state_d == S_TRAP) illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    generate
        if (MEM_WAIT_MAX > 0) begin : g_wait
            logic waiting;
            assign waiting = is_mem_state(state_q) && !mem_ready;

            mc_wait_counter #(
                .MAX (MEM_WAIT_MAX)
            ) u_wait (
                .clk         (clk),
                .rst_n       (rst_n),
                .waiting     (waiting),
                .mem_timeout (mem_timeout)
            );
        end else begin : g_no_wait
            assign mem_timeout = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. Each instruction is expanded into its
// expected cycle-by-cycle sequence (phase list, memory phases stretched by
// their wait counts) and replayed against the DUT with randomized inputs.
// Honours ILLEGAL_TRAP_EN the same way the design does.
module tb_multicycle_controller;
    import mc_ctrl_pkg::*;

    localparam int unsigned WMAX = 4;

    localparam logic [14:0] B_PCW  = 15'h4000;
    localparam logic [14:0] B_PCWC = 15'h2000;
    localparam logic [14:0] B_IORD = 15'h1000;
    localparam logic [14:0] B_MR   = 15'h0800;
    localparam logic [14:0] B_MW   = 15'h0400;
    localparam logic [14:0] B_IRW  = 15'h0200;
    localparam logic [14:0] B_M2R  = 15'h0100;
    localparam logic [14:0] B_RW   = 15'h0080;
    localparam logic [14:0] B_SA   = 15'h0040;
    localparam logic [14:0] B_SB4  = 15'h0010;
    localparam logic [14:0] B_SBI  = 15'h0020;
    localparam logic [14:0] B_SUB  = 15'h0004;
    localparam logic [14:0] B_FN   = 15'h0008;
    localparam logic [14:0] B_PSRC = 15'h0002;
    localparam logic [14:0] B_DONE = 15'h0001;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_write, alu_src_a, pc_source, instr_done;
    logic [1:0] alu_src_b, alu_op;
    logic       mem_timeout, illegal;
    logic [3:0] state;

    typedef struct {
        logic [3:0]  st;
        logic [14:0] outs;
        logic        rdy;
        logic [6:0]  opc;
        logic        zro;
        logic        to;
        logic        ill;
    } cyc_t;

    cyc_t plan[$];
    bit   to_sticky;
    int   n_checks;
    int   n_errors;

    multicycle_controller #(.MEM_WAIT_MAX(WMAX)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .instr_done    (instr_done),
        .mem_timeout   (mem_timeout),
        .illegal       (illegal),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [14:0] dut_outs();
        return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                instr_done};
    endfunction

    function automatic logic [6:0] rnd7();
        return 7'($urandom);
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return op == OP_R || op == OP_LOAD || op == OP_STORE || op == OP_BRANCH;
    endfunction

    task automatic push(input logic [3:0] st, input logic [14:0] outs, input logic rdy,
                        input logic [6:0] opc, input logic zro, input logic to, input logic ill);
        cyc_t c;
        c.st = st; c.outs = outs; c.rdy = rdy; c.opc = opc;
        c.zro = zro; c.to = to; c.ill = ill;
        plan.push_back(c);
    endtask

    // Cycle with no memory access: mem_ready is a don't-care, so randomize it.
    task automatic push_plain(input logic [3:0] st, input logic [14:0] outs,
                              input logic [6:0] opc, input logic zro, input logic ill);
        push(st, outs, 1'($urandom), opc, zro, to_sticky, ill);
    endtask

    // Memory phase: 'waits' stalled cycles followed by the completing cycle.
    task automatic push_access(input logic [3:0] st, input logic [14:0] o_wait,
                               input logic [14:0] o_done, input int waits);
        for (int i = 0; i <= waits; i++) begin
            logic rdy;
            rdy = (i == waits);
            push(st, rdy ? o_done : o_wait, rdy, rnd7(), 1'($urandom),
                 to_sticky || (i >= int'(WMAX)), 1'b0);
        end
        if (waits >= int'(WMAX)) to_sticky = 1'b1;
    endtask

    task automatic push_instr(input logic [6:0] op, input int wf, input int wm, input logic zro);
        push_access(S_FETCH, B_MR | B_SB4, B_MR | B_SB4 | B_IRW | B_PCW, wf);
        if (!is_legal(op)) begin
`ifdef ILLEGAL_TRAP_EN
            push_plain(S_DECODE, B_SBI, op, 1'($urandom), 1'b0);
            for (int i = 0; i < 20; i++) push_plain(S_TRAP, '0, rnd7(), 1'($urandom), 1'b1);
`else
            push_plain(S_DECODE, B_SBI | B_DONE, op, 1'($urandom), 1'b0);
`endif
            return;
        end
        push_plain(S_DECODE, B_SBI, op, 1'($urandom), 1'b0);
        if (op == OP_R) begin
            push_plain(S_EXEC_R, B_SA | B_FN, rnd7(), 1'($urandom), 1'b0);
            push_plain(S_WB_R, B_RW | B_DONE, rnd7(), 1'($urandom), 1'b0);
        end else if (op == OP_LOAD) begin
            push_plain(S_ADDR, B_SA | B_SBI, rnd7(), 1'($urandom), 1'b0);
            push_access(S_MEM_RD, B_MR | B_IORD, B_MR | B_IORD, wm);
            push_plain(S_WB_MEM, B_RW | B_M2R | B_DONE, rnd7(), 1'($urandom), 1'b0);
        end else if (op == OP_STORE) begin
            push_plain(S_ADDR, B_SA | B_SBI, rnd7(), 1'($urandom), 1'b0);
            push_access(S_MEM_WR, B_MW | B_IORD, B_MW | B_IORD | B_DONE, wm);
        end else begin
            push_plain(S_BRANCH, B_SA | B_SUB | B_PCWC | B_PSRC | B_DONE, rnd7(), zro, 1'b0);
        end
    endtask

    task automatic run_n(input int n);
        for (int k = 0; k < n && plan.size() > 0; k++) begin
            cyc_t c;
            c = plan.pop_front();
            @(negedge clk);
            mem_ready = c.rdy;
            opcode    = c.opc;
            zero      = c.zro;
            #1;
            check("state",   32'(state),       32'(c.st));
            check("outputs", 32'(dut_outs()),  32'(c.outs));
            check("timeout", 32'(mem_timeout), 32'(c.to));
            check("illegal", 32'(illegal),     32'(c.ill));
        end
    endtask

    task automatic run_plan();
        run_n(plan.size());
    endtask

    // Assert reset mid-cycle, check it acts at once and holds, release just
    // after a rising edge so the first checked cycle is a full IDLE cycle.
    task automatic do_reset(input int n);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i <= n; i++) begin
            if (i > 0) begin
                @(negedge clk);
                mem_ready = 1'($urandom);
                #1;
            end
            check("rst_state",   32'(state),       32'(0));
            check("rst_outputs", 32'(dut_outs()),  32'(0));
            check("rst_timeout", 32'(mem_timeout), 32'(0));
            check("rst_illegal", 32'(illegal),     32'(0));
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        to_sticky = 1'b0;
        plan.delete();
        push_plain(S_IDLE, '0, rnd7(), 1'($urandom), 1'b0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        to_sticky = 1'b0;
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        opcode    = '0;
        zero      = 1'b0;

        do_reset(2);

        // Directed instruction mix at zero and short wait states.
        push_instr(OP_R, 0, 0, 1'b0);
        push_instr(OP_LOAD, 0, 3, 1'b0);
        push_instr(OP_BRANCH, 0, 0, 1'b1);
        push_instr(OP_BRANCH, 0, 0, 1'b0);
        push_instr(OP_STORE, 0, 0, 1'b0);
        push_instr(OP_STORE, 1, 2, 1'b0);
        push_instr(OP_LOAD, 0, 0, 1'b0);
        run_plan();

        // Long FETCH stall trips the wait timeout; FSM still completes.
        push_instr(OP_R, 6, 0, 1'b0);
        push_instr(OP_BRANCH, 0, 0, 1'b1);
        run_plan();

        // Randomized instruction stream from a clean state.
        do_reset(1);
        for (int i = 0; i < 60; i++) begin
            logic [6:0] op;
            int         sel;
            int         wf;
            int         wm;
`ifdef ILLEGAL_TRAP_EN
            sel = $urandom_range(0, 3);
`else
            sel = $urandom_range(0, 4);
`endif
            case (sel)
                0: op = OP_R;
                1: op = OP_LOAD;
                2: op = OP_STORE;
                3: op = OP_BRANCH;
                default: begin
                    op = rnd7();
                    while (is_legal(op)) op = rnd7();
                end
            endcase
            wf = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : 0;
            wm = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 5) : 0;
            push_instr(op, wf, wm, 1'($urandom));
            run_plan();
        end

        // Reset in the middle of a pending load access.
        do_reset(0);
        push_instr(OP_LOAD, 0, 5, 1'b0);
        run_n(6);
        do_reset(1);
        push_instr(OP_R, 0, 0, 1'b0);
        run_plan();

        // Unknown opcode 1111111.
        push_instr(7'b1111111, 0, 0, 1'b0);
        run_plan();
`ifdef ILLEGAL_TRAP_EN
        do_reset(1);
`endif
        push_instr(OP_STORE, 0, 1, 1'b0);
        push_instr(OP_R, 0, 0, 1'b0);
        run_plan();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
